icache_fetch_if: RTL and testbench

Responder side of the fetch-to-icache request/response interface. It accepts per-cycle fetch requests (valid, vaddr, invalidate/retry controls) and returns a 32-bit instruction with a page-fault flag. A one-line fetch buffer serves hits in the same cycle. Misses are forwarded as line requests to the icache array side through a small FSM. Sits between the fetch stage and the icache core.

---
 rtl/icache_fetch_if.sv | 142 ++++++++++++++
 tb/tb_icache_fetch_if.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_if.sv
// Fetch-side responder for the icache. A one-line fetch buffer answers hits in the same cycle.
// Misses go out as line requests to the icache array through a four-state FSM.
module icache_fetch_if #(
    parameter int VADDR_W = 40,
    parameter int LINE_W  = 128,
    parameter int INST_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    input  logic [VADDR_W-1:0] req_vaddr_i,
    input  logic               req_invalidate_icache_i,
    input  logic               req_invalidate_buffer_i,
    input  logic               req_inval_fetch_i,
    output logic               resp_valid_o,
    output logic [INST_W-1:0]  resp_data_o,
    output logic               resp_instr_page_fault_o,
    output logic               ic_req_valid_o,
    output logic [VADDR_W-1:0] ic_req_vaddr_o,
    input  logic               ic_req_ready_i,
    output logic               ic_req_kill_o,
    output logic               ic_flush_o,
    input  logic               ic_resp_valid_i,
    input  logic [LINE_W-1:0]  ic_resp_data_i,
    input  logic               ic_resp_xcpt_i
);

    localparam int TAG_W = VADDR_W - 4;
    localparam int WORDS = LINE_W / INST_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t             state_reg, state_next;
    logic [TAG_W-1:0]   addr_reg, addr_next;
    logic               buf_valid_reg;
    logic [TAG_W-1:0]   buf_tag_reg;
    logic [LINE_W-1:0]  buf_data_reg;
    logic               buf_xcpt_reg;
    logic               flush_reg;

    logic               hit;
    logic               abort;
    logic               fill;
    logic [INST_W-1:0]  buf_words [WORDS];
    logic               unused_vaddr_lsb;

    assign unused_vaddr_lsb = ^req_vaddr_i[1:0];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign buf_words[gi] = buf_data_reg[gi*INST_W +: INST_W];
        end
    endgenerate

    assign abort = req_inval_fetch_i | req_invalidate_icache_i;
    assign hit   = req_valid_i & buf_valid_reg
                 & (req_vaddr_i[VADDR_W-1:4] == buf_tag_reg)
                 & ~req_invalidate_buffer_i & ~req_inval_fetch_i;

    assign resp_valid_o            = hit;
    assign resp_instr_page_fault_o = hit & buf_xcpt_reg;
    assign resp_data_o             = (hit & ~buf_xcpt_reg) ? buf_words[req_vaddr_i[3:2]] : '0;

    assign ic_req_vaddr_o = (state_reg == ST_REQ) ? {addr_reg, 4'b0000} : '0;
    assign ic_flush_o     = flush_reg;

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        fill           = 1'b0;
        ic_req_valid_o = 1'b0;
        ic_req_kill_o  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid_i & ~hit & ~abort) begin
                    addr_next  = req_vaddr_i[VADDR_W-1:4];
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // Valid is withheld on abort so the icache can never accept a request we then forget.
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    ic_req_valid_o = 1'b1;
                    if (ic_req_ready_i) state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ic_resp_valid_i) begin
                    fill       = ~abort;
                    state_next = ST_IDLE;
                end else if (abort) begin
                    ic_req_kill_o = 1'b1;
                    state_next    = ST_DROP;
                end
            end
            ST_DROP: begin
                if (ic_resp_valid_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            flush_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            flush_reg <= req_invalidate_icache_i;
        end
    end

    // Any invalidation wins over a same-cycle fill, leaving the buffer empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
            buf_xcpt_reg  <= 1'b0;
        end else begin
            if (fill) begin
                buf_tag_reg  <= addr_reg;
                buf_data_reg <= ic_resp_data_i;
                buf_xcpt_reg <= ic_resp_xcpt_i;
            end
            if (req_invalidate_buffer_i | abort)
                buf_valid_reg <= 1'b0;
            else if (fill)
                buf_valid_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_fetch_if.sv
// Cycle-stepped scoreboard bench for icache_fetch_if; the bench plays the icache array side.
module tb_icache_fetch_if;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_valid_i = 1'b0;
    logic [39:0]  req_vaddr_i = '0;
    logic         req_invalidate_icache_i = 1'b0;
    logic         req_invalidate_buffer_i = 1'b0;
    logic         req_inval_fetch_i = 1'b0;
    logic         resp_valid_o;
    logic [31:0]  resp_data_o;
    logic         resp_instr_page_fault_o;
    logic         ic_req_valid_o;
    logic [39:0]  ic_req_vaddr_o;
    logic         ic_req_ready_i = 1'b0;
    logic         ic_req_kill_o;
    logic         ic_flush_o;
    logic         ic_resp_valid_i = 1'b0;
    logic [127:0] ic_resp_data_i = '0;
    logic         ic_resp_xcpt_i = 1'b0;

    icache_fetch_if dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .req_valid_i             (req_valid_i),
        .req_vaddr_i             (req_vaddr_i),
        .req_invalidate_icache_i (req_invalidate_icache_i),
        .req_invalidate_buffer_i (req_invalidate_buffer_i),
        .req_inval_fetch_i       (req_inval_fetch_i),
        .resp_valid_o            (resp_valid_o),
        .resp_data_o             (resp_data_o),
        .resp_instr_page_fault_o (resp_instr_page_fault_o),
        .ic_req_valid_o          (ic_req_valid_o),
        .ic_req_vaddr_o          (ic_req_vaddr_o),
        .ic_req_ready_i          (ic_req_ready_i),
        .ic_req_kill_o           (ic_req_kill_o),
        .ic_flush_o              (ic_flush_o),
        .ic_resp_valid_i         (ic_resp_valid_i),
        .ic_resp_data_i          (ic_resp_data_i),
        .ic_resp_xcpt_i          (ic_resp_xcpt_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rv;
        logic [31:0] data;
        logic        pf;
        logic        icv;
        logic [39:0] iaddr;
        logic        kill;
        logic        flush;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic logic [31:0] word_of(input logic [39:0] pc);
        return pc[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] line_of(input logic [39:0] base);
        return {word_of(base + 40'd12), word_of(base + 40'd8), word_of(base + 40'd4), word_of(base)};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic drv(input logic v, input logic [39:0] pc, input logic ii, input logic ib,
                       input logic ifx, input logic rdy, input logic rv,
                       input logic [39:0] rl, input logic rx);
        req_valid_i             = v;
        req_vaddr_i             = pc;
        req_invalidate_icache_i = ii;
        req_invalidate_buffer_i = ib;
        req_inval_fetch_i       = ifx;
        ic_req_ready_i          = rdy;
        ic_resp_valid_i         = rv;
        ic_resp_data_i          = rv ? line_of(rl) : '0;
        ic_resp_xcpt_i          = rx;
    endtask

    task automatic step(input logic rv, input logic [31:0] data, input logic pf, input logic icv,
                        input logic [39:0] iaddr, input logic kill, input logic flush);
        exp_t e;
        e = '{rv, data, pf, icv, iaddr, kill, flush};
        sb_q.push_back(e);
        @(negedge clk_i);
        e = sb_q.pop_front();
        $display("cyc %0d pc=%0h rv=%0b data=%0h pf=%0b icv=%0b ia=%0h kill=%0b flush=%0b",
                 cyc, req_vaddr_i, resp_valid_o, resp_data_o, resp_instr_page_fault_o,
                 ic_req_valid_o, ic_req_vaddr_o, ic_req_kill_o, ic_flush_o);
        check_eq("resp_valid", 64'(resp_valid_o), 64'(e.rv));
        check_eq("resp_data", 64'(resp_data_o), 64'(e.data));
        check_eq("page_fault", 64'(resp_instr_page_fault_o), 64'(e.pf));
        check_eq("ic_req_valid", 64'(ic_req_valid_o), 64'(e.icv));
        check_eq("ic_req_vaddr", 64'(ic_req_vaddr_o), 64'(e.iaddr));
        check_eq("ic_req_kill", 64'(ic_req_kill_o), 64'(e.kill));
        check_eq("ic_flush", 64'(ic_flush_o), 64'(e.flush));
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        // Reset: everything quiet
        drv(1'b1, 40'h1000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;

        // Cold miss on 0x1000, response two cycles after accept
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 40'h1000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h1000, 0, 0, 0, 1, 1, 40'h1000, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h1000, 0, 0, 0, 1, 0, 0, 0);
        step(1, word_of(40'h1000), 0, 0, 0, 0, 0);

        // Line hits on the remaining words
        for (int i = 1; i < 4; i++) begin
            drv(1, 40'h1000 + 40'(4 * i), 0, 0, 0, 1, 0, 0, 0);
            step(1, word_of(40'h1000 + 40'(4 * i)), 0, 0, 0, 0, 0);
        end

        // Next line misses; fill carries a page fault
        drv(1, 40'h1010, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 40'h1010, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h1010, 0, 0, 0, 1, 1, 40'h1010, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h1014, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);

        // Retry in WAIT: kill, then the late response is discarded
        drv(1, 40'h2000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 40'h2000, 0, 0);
        drv(1, 40'h2000, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        drv(1, 40'h2000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2000, 0, 0, 0, 1, 1, 40'h2000, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Back-pressure: three stalled cycles, request held stable
        drv(1, 40'h2000, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 40'h2000, 0, 0);
        drv(1, 40'h2000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 40'h2000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2000, 0, 0, 0, 1, 1, 40'h2000, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2008, 0, 0, 0, 1, 0, 0, 0);
        step(1, word_of(40'h2008), 0, 0, 0, 0, 0);

        // Buffer invalidate during a hit: no response, and the line is refetched
        drv(1, 40'h2008, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2008, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 40'h2000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h2008, 0, 0, 0, 1, 1, 40'h2000, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drv(1, 40'h200C, 0, 0, 0, 1, 0, 0, 0);
        step(1, word_of(40'h200C), 0, 0, 0, 0, 0);

        // Icache flush: one-cycle pulse, buffer emptied
        drv(1, 40'h2008, 1, 0, 0, 1, 0, 0, 0);
        step(1, word_of(40'h2008), 0, 0, 0, 0, 0);
        drv(0, 40'h2008, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        drv(1, 40'h2008, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 40'h2000, 0, 0);

        // Reset while in WAIT
        drv(0, 40'h2008, 0, 0, 0, 1, 0, 0, 0);
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        drv(1, 40'h3000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 40'h3000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
